// File: rtl/isqrt_fsm_pkg.sv
// Shared types and width helpers for the isqrt sum FSM and its return-side accumulator.
package isqrt_fsm_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } issue_state_t;

    // Index counters need at least one bit even for single-argument sets.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/isqrt_sum_accum.sv
// Return side: sums isqrt results of one set in arrival order and publishes the total
// one cycle after its last root arrives; flags roots that arrive with nothing in flight.
module isqrt_sum_accum
    import isqrt_fsm_pkg::*;
#(
    parameter int N_ARGS = 3,
    parameter int Y_W    = 16,
    parameter int RES_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             y_vld,
    input  logic [Y_W-1:0]   y,
    input  logic             busy,
    output logic [RES_W-1:0] res,
    output logic             res_vld,
    output logic             err,
    output logic             sum_done
);

    localparam int IDX_W = idx_width(N_ARGS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ARGS - 1);

    logic [IDX_W-1:0] ridx;
    logic [RES_W-1:0] acc;

    // The first root of a set restarts the sum, so no clear cycle is needed between sets.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ridx     <= '0;
            acc      <= '0;
            sum_done <= 1'b0;
            res      <= '0;
            res_vld  <= 1'b0;
            err      <= 1'b0;
        end else begin
            res_vld  <= sum_done;
            sum_done <= 1'b0;
            if (sum_done) begin
                res <= acc;
            end
            if (y_vld) begin
                if (busy) begin
                    acc <= ((ridx == '0) ? '0 : acc) + RES_W'(y);
                    if (ridx == LAST_IDX) begin
                        ridx     <= '0;
                        sum_done <= 1'b1;
                    end else begin
                        ridx <= ridx + IDX_W'(1);
                    end
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/isqrt_sum_n_pipe_fsm.sv
// Issue FSM for a shared pipelined isqrt: accepts N_ARGS-word sets, streams one word
// per cycle to the isqrt, and bounds the number of sets in flight to MAX_OUTST.
module isqrt_sum_n_pipe_fsm
    import isqrt_fsm_pkg::*;
#(
    parameter int N_ARGS    = 3,
    parameter int ARG_W     = 32,
    parameter int RES_W     = 32,
    parameter int MAX_OUTST = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    arg_vld,
    output logic                    arg_rdy,
    input  logic [N_ARGS*ARG_W-1:0] args,
    output logic                    res_vld,
    output logic [RES_W-1:0]        res,
    output logic                    err,
    output logic                    isqrt_x_vld,
    output logic [ARG_W-1:0]        isqrt_x,
    input  logic                    isqrt_y_vld,
    input  logic [ARG_W/2-1:0]      isqrt_y
);

    localparam int Y_W   = ARG_W / 2;
    localparam int IDX_W = idx_width(N_ARGS);
    localparam int OUT_W = cnt_width(MAX_OUTST);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ARGS - 1);
    localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(MAX_OUTST);

    if (N_ARGS < 1) begin : g_chk_n_args
        $error("isqrt_sum_n_pipe_fsm: N_ARGS must be at least 1");
    end
    if ((ARG_W % 2) != 0) begin : g_chk_arg_w
        $error("isqrt_sum_n_pipe_fsm: ARG_W must be even");
    end
    if (RES_W < Y_W + $clog2(N_ARGS)) begin : g_chk_res_w
        $error("isqrt_sum_n_pipe_fsm: RES_W too narrow for the sum of N_ARGS roots");
    end
    if (MAX_OUTST < 1) begin : g_chk_outst
        $error("isqrt_sum_n_pipe_fsm: MAX_OUTST must be at least 1");
    end

    issue_state_t            state, next_state;
    logic [IDX_W-1:0]        idx, next_idx;
    logic [N_ARGS*ARG_W-1:0] args_q;
    logic [OUT_W-1:0]        outst;
    logic                    can_accept;
    logic                    accept;
    logic                    sum_done;
    logic                    busy;

    // A set accepted while the previous one issues its last word starts issuing from
    // the latch on the next cycle, keeping isqrt_x_vld continuous.
    always_comb begin
        next_state  = state;
        next_idx    = idx;
        arg_rdy     = 1'b0;
        accept      = 1'b0;
        isqrt_x_vld = 1'b0;
        isqrt_x     = '0;
        can_accept  = (outst < OUT_MAX);
        case (state)
            IDLE: begin
                arg_rdy = can_accept;
                if (arg_vld && can_accept) begin
                    accept      = 1'b1;
                    isqrt_x_vld = 1'b1;
                    isqrt_x     = args[ARG_W-1:0];
                    next_idx    = (N_ARGS > 1) ? IDX_W'(1) : '0;
                    next_state  = (N_ARGS > 1) ? ISSUE : IDLE;
                end
            end
            ISSUE: begin
                isqrt_x_vld = 1'b1;
                isqrt_x     = args_q[int'(idx)*ARG_W +: ARG_W];
                next_idx    = idx + IDX_W'(1);
                if (idx == LAST_IDX) begin
                    arg_rdy  = can_accept;
                    next_idx = '0;
                    if (arg_vld && can_accept) begin
                        accept = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= next_state;
            idx   <= next_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            args_q <= '0;
        end else if (accept) begin
            args_q <= args;
        end
    end

    // A set stops counting as in flight on the edge that raises its res_vld.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outst <= '0;
        end else begin
            case ({accept, sum_done})
                2'b10:   outst <= outst + OUT_W'(1);
                2'b01:   outst <= outst - OUT_W'(1);
                default: outst <= outst;
            endcase
        end
    end

    assign busy = (outst != '0);

    isqrt_sum_accum #(
        .N_ARGS (N_ARGS),
        .Y_W    (Y_W),
        .RES_W  (RES_W)
    ) u_accum (
        .clk      (clk),
        .rst      (rst),
        .y_vld    (isqrt_y_vld),
        .y        (isqrt_y),
        .busy     (busy),
        .res      (res),
        .res_vld  (res_vld),
        .err      (err),
        .sum_done (sum_done)
    );

endmodule

// File: tb/tb_isqrt_sum_n_pipe_fsm.sv
// Bench for isqrt_sum_n_pipe_fsm: three configurations, each fed by a 4-stage isqrt model,
// with expected sums queued at stimulus time and popped when res_vld pulses.
module tb_isqrt_sum_n_pipe_fsm;

    localparam int L = 4;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: N_ARGS=3, MAX_OUTST=4
    logic        a_arg_vld, a_arg_rdy, a_res_vld, a_err, a_xv, a_yv, a_inj;
    logic [95:0] a_args;
    logic [31:0] a_res, a_x;
    logic [15:0] a_y, a_inj_y;
    // Instance B: N_ARGS=3, MAX_OUTST=1
    logic        b_arg_vld, b_arg_rdy, b_res_vld, b_err, b_xv, b_yv;
    logic [95:0] b_args;
    logic [31:0] b_res, b_x;
    logic [15:0] b_y;
    // Instance C: N_ARGS=1, MAX_OUTST=4
    logic        c_arg_vld, c_arg_rdy, c_res_vld, c_err, c_xv, c_yv;
    logic [31:0] c_args, c_res, c_x;
    logic [15:0] c_y;

    isqrt_sum_n_pipe_fsm #(.N_ARGS(3), .ARG_W(32), .RES_W(32), .MAX_OUTST(4)) dut_a (
        .clk(clk), .rst(rst), .arg_vld(a_arg_vld), .arg_rdy(a_arg_rdy), .args(a_args),
        .res_vld(a_res_vld), .res(a_res), .err(a_err), .isqrt_x_vld(a_xv), .isqrt_x(a_x),
        .isqrt_y_vld(a_yv), .isqrt_y(a_y));

    isqrt_sum_n_pipe_fsm #(.N_ARGS(3), .ARG_W(32), .RES_W(32), .MAX_OUTST(1)) dut_b (
        .clk(clk), .rst(rst), .arg_vld(b_arg_vld), .arg_rdy(b_arg_rdy), .args(b_args),
        .res_vld(b_res_vld), .res(b_res), .err(b_err), .isqrt_x_vld(b_xv), .isqrt_x(b_x),
        .isqrt_y_vld(b_yv), .isqrt_y(b_y));

    isqrt_sum_n_pipe_fsm #(.N_ARGS(1), .ARG_W(32), .RES_W(32), .MAX_OUTST(4)) dut_c (
        .clk(clk), .rst(rst), .arg_vld(c_arg_vld), .arg_rdy(c_arg_rdy), .args(c_args),
        .res_vld(c_res_vld), .res(c_res), .err(c_err), .isqrt_x_vld(c_xv), .isqrt_x(c_x),
        .isqrt_y_vld(c_yv), .isqrt_y(c_y));

    function automatic logic [15:0] isqrt_f(input logic [31:0] v);
        logic [15:0] r;
        logic [15:0] t;
        r = '0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (16'(1) << b);
            if (64'(t) * 64'(t) <= 64'(v)) r = t;
        end
        return r;
    endfunction

    // isqrt models: result valid L cycles after the operand cycle, cleared by the shared reset
    logic [L-1:0] a_vp, b_vp, c_vp;
    logic [15:0]  a_yp [L];
    logic [15:0]  b_yp [L];
    logic [15:0]  c_yp [L];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            a_vp <= '0;
            b_vp <= '0;
            c_vp <= '0;
        end else begin
            a_vp <= {a_vp[L-2:0], a_xv};
            b_vp <= {b_vp[L-2:0], b_xv};
            c_vp <= {c_vp[L-2:0], c_xv};
        end
    end

    always @(posedge clk) begin
        a_yp[0] <= isqrt_f(a_x);
        b_yp[0] <= isqrt_f(b_x);
        c_yp[0] <= isqrt_f(c_x);
        for (int i = 1; i < L; i++) begin
            a_yp[i] <= a_yp[i-1];
            b_yp[i] <= b_yp[i-1];
            c_yp[i] <= c_yp[i-1];
        end
    end

    assign a_yv = a_vp[L-1] | a_inj;
    assign a_y  = a_vp[L-1] ? a_yp[L-1] : a_inj_y;
    assign b_yv = b_vp[L-1];
    assign b_y  = b_yp[L-1];
    assign c_yv = c_vp[L-1];
    assign c_y  = c_yp[L-1];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [31:0] exp_a[$], exp_b[$], exp_c[$];
    int          rcyc_a[$], rcyc_b[$], rcyc_c[$];
    logic [31:0] xlog_a[$], exp_x[$];
    int          xcyc_a[$];

    always @(negedge clk) begin
        if (a_xv) begin
            xlog_a.push_back(a_x);
            xcyc_a.push_back(cyc);
        end
        if (a_res_vld) begin
            rcyc_a.push_back(cyc);
            if (exp_a.size() == 0) checkOutput("a_res_vld_unexpected", a_res_vld, 0);
            else checkOutput("a_res", a_res, exp_a.pop_front());
        end
        if (b_res_vld) begin
            rcyc_b.push_back(cyc);
            if (exp_b.size() == 0) checkOutput("b_res_vld_unexpected", b_res_vld, 0);
            else checkOutput("b_res", b_res, exp_b.pop_front());
        end
        if (c_res_vld) begin
            rcyc_c.push_back(cyc);
            if (exp_c.size() == 0) checkOutput("c_res_vld_unexpected", c_res_vld, 0);
            else checkOutput("c_res", c_res, exp_c.pop_front());
        end
    end

    // Called just after a rising edge; returns just after the edge that accepts the set.
    task automatic applyStimulus(input logic [95:0] v, input logic [31:0] exp);
        int t;
        a_arg_vld = 1'b1;
        a_args    = v;
        for (t = 0; t < 40; t++) begin
            @(negedge clk);
            if (a_arg_rdy) break;
            @(posedge clk);
            #1;
        end
        checkOutput("a_accept_in_time", 64'(t < 40), 1);
        exp_a.push_back(exp);
        @(posedge clk);
        #1;
        a_arg_vld = 1'b0;
        a_args    = {$urandom, $urandom, $urandom};
    endtask

    task automatic checkXLog(input string tag);
        checkOutput({tag, "_count"}, xlog_a.size(), exp_x.size());
        for (int i = 0; i < exp_x.size() && i < xlog_a.size(); i++) begin
            checkOutput({tag, "_val"}, xlog_a[i], exp_x[i]);
            if (i > 0) checkOutput({tag, "_gap"}, xcyc_a[i] - xcyc_a[i-1], 1);
        end
    endtask

    // Returns the number of cycles arg_rdy stays low, starting just after a rising edge.
    task automatic waitRdyB(output int low);
        low = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (b_arg_rdy) break;
            low++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int low;
        logic [31:0] c_stream [3];
        logic [31:0] c_expect [3];

        rst = 1'b1;
        a_arg_vld = 1'b0; a_args = '0; a_inj = 1'b0; a_inj_y = '0;
        b_arg_vld = 1'b0; b_args = '0;
        c_arg_vld = 1'b0; c_args = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_res", a_res, 0);
        checkOutput("rst_res_vld", a_res_vld, 0);
        checkOutput("rst_err", a_err, 0);
        checkOutput("rst_arg_rdy", a_arg_rdy, 1);
        checkOutput("rst_x_vld", a_xv, 0);
        checkOutput("rst_x", a_x, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] test 1: single set {1,4,9}");
        xlog_a.delete(); xcyc_a.delete();
        applyStimulus({32'd9, 32'd4, 32'd1}, 32'd6);
        lat = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (a_res_vld) break;
            @(posedge clk);
            lat++;
        end
        // edges from the accept edge to the edge raising res_vld: N-1 + L + 1
        checkOutput("t1_latency", lat, 3 - 1 + L + 1);
        repeat (3) @(posedge clk);
        #1;
        exp_x = '{32'd1, 32'd4, 32'd9};
        checkXLog("t1_x");
        checkOutput("t1_drained", exp_a.size(), 0);

        $display("[TB] test 2: back-to-back sets");
        xlog_a.delete(); xcyc_a.delete(); rcyc_a.delete();
        applyStimulus({32'd36, 32'd25, 32'd16}, 32'd15);
        applyStimulus({32'hFFFF_FFFF, 32'd1, 32'd0}, 32'd65536);
        repeat (20) @(posedge clk);
        #1;
        exp_x = '{32'd16, 32'd25, 32'd36, 32'd0, 32'd1, 32'hFFFF_FFFF};
        checkXLog("t2_x");
        checkOutput("t2_res_count", rcyc_a.size(), 2);
        if (rcyc_a.size() == 2) checkOutput("t2_res_gap", rcyc_a[1] - rcyc_a[0], 3);
        checkOutput("t2_drained", exp_a.size(), 0);

        $display("[TB] test 3: MAX_OUTST=1 with arg_vld held high");
        rcyc_b.delete();
        b_arg_vld = 1'b1;
        b_args = {32'd9, 32'd4, 32'd1};
        exp_b.push_back(32'd6);
        waitRdyB(low);
        checkOutput("t3_first_rdy", low, 0);
        @(posedge clk);
        #1;
        b_args = {32'd36, 32'd25, 32'd16};
        exp_b.push_back(32'd15);
        waitRdyB(low);
        checkOutput("t3_rdy_low_cycles", low, 3 - 1 + L + 1);
        checkOutput("t3_rdy_with_res_vld", b_res_vld, 1);
        @(posedge clk);
        #1;
        b_arg_vld = 1'b0;
        b_args = {$urandom, $urandom, $urandom};
        waitRdyB(low);
        checkOutput("t3_rdy_low_cycles_2", low, 3 - 1 + L + 1);
        checkOutput("t3_rdy_with_res_vld_2", b_res_vld, 1);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("t3_res_count", rcyc_b.size(), 2);
        checkOutput("t3_drained", exp_b.size(), 0);

        $display("[TB] test 4: N_ARGS=1 streaming");
        rcyc_c.delete();
        c_stream = '{32'd49, 32'd64, 32'd81};
        c_expect = '{32'd7, 32'd8, 32'd9};
        c_arg_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            c_args = c_stream[i];
            exp_c.push_back(c_expect[i]);
            @(negedge clk);
            checkOutput("t4_arg_rdy", c_arg_rdy, 1);
            @(posedge clk);
            #1;
        end
        c_arg_vld = 1'b0;
        c_args = $urandom;
        repeat (15) @(posedge clk);
        #1;
        checkOutput("t4_res_count", rcyc_c.size(), 3);
        if (rcyc_c.size() == 3) begin
            checkOutput("t4_res_gap_0", rcyc_c[1] - rcyc_c[0], 1);
            checkOutput("t4_res_gap_1", rcyc_c[2] - rcyc_c[1], 1);
        end
        checkOutput("t4_err", c_err, 0);

        $display("[TB] test 5: reset during issue");
        rcyc_a.delete();
        applyStimulus({32'd100, 32'd100, 32'd100}, 32'd30);
        @(negedge clk);
        checkOutput("t5_mid_issue", a_xv, 1);
        rst = 1'b1;
        exp_a.delete();
        @(negedge clk);
        checkOutput("t5_rst_x_vld", a_xv, 0);
        checkOutput("t5_rst_arg_rdy", a_arg_rdy, 1);
        checkOutput("t5_rst_res", a_res, 0);
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        checkOutput("t5_no_res_vld", rcyc_a.size(), 0);
        applyStimulus({32'd4, 32'd4, 32'd4}, 32'd6);
        repeat (15) @(posedge clk);
        #1;
        checkOutput("t5_res_count", rcyc_a.size(), 1);
        checkOutput("t5_drained", exp_a.size(), 0);

        $display("[TB] test 6: stray isqrt result");
        checkOutput("t6_err_before", a_err, 0);
        a_inj   = 1'b1;
        a_inj_y = 16'h1234;
        @(posedge clk);
        #1;
        a_inj   = 1'b0;
        a_inj_y = '0;
        @(negedge clk);
        checkOutput("t6_err_set", a_err, 1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("t6_err_sticky", a_err, 1);
        checkOutput("t6_no_res_vld", rcyc_a.size(), 1);
        checkOutput("t6_res_held", a_res, 6);
        checkOutput("t6_b_err", b_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
